// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine: on a miss, reads the 8 words of the missing
// 32-byte line one at a time over a req/valid handshake, then pulses update.
module icache_line_fill (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC,
    input  logic        miss,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] w0,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output logic [31:0] w3,
    output logic [31:0] w4,
    output logic [31:0] w5,
    output logic [31:0] w6,
    output logic [31:0] w7,
    output logic        update,
    output logic        stall
);

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LINE_WORDS  = 8;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned CNT_W       = $clog2(LINE_WORDS);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        UPDATE = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] line_q [LINE_WORDS];
    logic              beat;

    // Next-state logic; a beat is a completed word transfer while filling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    base_d  = PC & ~OFFSET_MASK;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_valid) begin
                    beat  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE:  state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, line buffer and registered outputs decoded from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            update   <= 1'b0;
            stall    <= 1'b0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            mem_req  <= (state_d == FILL);
            mem_addr <= base_d + ADDR_W'({cnt_d, 2'b00});
            update   <= (state_d == UPDATE);
            stall    <= (state_d == FILL) || (state_d == UPDATE);
            if (beat) begin
                line_q[cnt_q] <= mem_rdata;
            end
        end
    end

    assign w0 = line_q[0];
    assign w1 = line_q[1];
    assign w2 = line_q[2];
    assign w3 = line_q[3];
    assign w4 = line_q[4];
    assign w5 = line_q[5];
    assign w6 = line_q[6];
    assign w7 = line_q[7];

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed vector table, hand-written
// corner sequences and randomized fills checked against a line-level memory model.
module tb_icache_line_fill;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] PC;
    logic        miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic        update;
    logic        stall;

    icache_line_fill dut (
        .CLK(CLK), .RST_N(RST_N), .PC(PC), .miss(miss),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7),
        .update(update), .stall(stall)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_w [8];

    typedef struct {
        logic [31:0] pc;
        int          wt;
        logic [31:0] key;
        logic [31:0] pc_after;
        logic [31:0] exp_base;
        int          exp_stall;
        logic [31:0] exp_w3;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] wsel(input int k);
        case (k)
            0:       return w0;
            1:       return w1;
            2:       return w2;
            3:       return w3;
            4:       return w4;
            5:       return w5;
            6:       return w6;
            default: return w7;
        endcase
    endfunction

    task automatic chk_line(input string nm);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s w%0d", nm, k), wsel(k), exp_w[k]);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " mem_req"}, 32'(mem_req), 32'd0);
        chk({nm, " stall"}, 32'(stall), 32'd0);
        chk({nm, " update"}, 32'(update), 32'd0);
    endtask

    // One complete line fill, starting at a sample point where the DUT accepts a miss.
    // Memory word k answers after waits[k] idle cycles with data = addr ^ key.
    // Returns at the sample point of the cycle after the update pulse.
    task automatic fill(input logic [31:0] pc, input int waits[8], input logic [31:0] key,
                        input bit hold_miss, input logic [31:0] pc_after,
                        output int stall_cyc, output logic [31:0] w3_out,
                        output logic [31:0] first_addr);
        logic [31:0] base;
        logic [31:0] addr;
        base      = pc - (pc % 32);
        stall_cyc = 0;
        miss      = 1'b1;
        PC        = pc;
        mem_valid = 1'b0;
        step();
        if (!hold_miss) miss = 1'b0;
        PC         = pc_after;
        first_addr = mem_addr;
        for (int k = 0; k < 8; k++) begin
            addr = base + 32'(4 * k);
            for (int c = 0; c <= waits[k]; c++) begin
                mem_valid = (c == waits[k]);
                mem_rdata = mem_valid ? (addr ^ key) : $urandom;
                chk($sformatf("fill req k%0d", k), 32'(mem_req), 32'd1);
                chk($sformatf("fill addr k%0d", k), mem_addr, addr);
                chk($sformatf("fill upd k%0d", k), 32'(update), 32'd0);
                if (stall) stall_cyc++;
                step();
            end
            exp_w[k] = addr ^ key;
        end
        mem_valid = 1'b0;
        chk("upd pulse", 32'(update), 32'd1);
        chk("upd req", 32'(mem_req), 32'd0);
        if (stall) stall_cyc++;
        chk_line("upd");
        w3_out = w3;
        step();
        chk_quiet("settle");
        chk_line("settle");
    endtask

    initial begin
        int          wt [8];
        int          stl;
        int          sum;
        int          gap;
        logic [31:0] w3v;
        logic [31:0] fa;

        vt[0] = '{32'h0000_1234, 0, 32'hA5A5_0000, 32'h0000_1234, 32'h0000_1220,  9, 32'hA5A5_122C};
        vt[1] = '{32'h0000_0040, 2, 32'hA5A5_0000, 32'h0000_0040, 32'h0000_0040, 25, 32'hA5A5_004C};
        vt[2] = '{32'h0000_0040, 1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0040, 17, 32'h0000_004C};
        vt[3] = '{32'hFFFF_FFFC, 0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFE0,  9, 32'hEDCB_A994};
        vt[4] = '{32'h0000_001F, 3, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0000, 33, 32'hFFFF_FFF3};

        RST_N     = 1'b0;
        miss      = 1'b0;
        PC        = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) exp_w[k] = '0;

        step();
        chk_quiet("reset");
        chk("reset addr", mem_addr, 32'd0);
        chk_line("reset");
        step();
        RST_N = 1'b1;
        step();
        chk_quiet("post reset");

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) wt[k] = vt[i].wt;
            fill(vt[i].pc, wt, vt[i].key, 1'b0, vt[i].pc_after, stl, w3v, fa);
            chk($sformatf("vec%0d stall", i), 32'(stl), 32'(vt[i].exp_stall));
            chk($sformatf("vec%0d w3", i), w3v, vt[i].exp_w3);
            chk($sformatf("vec%0d base", i), fa, vt[i].exp_base);
            step();
            chk_quiet($sformatf("vec%0d idle", i));
        end

        // Spurious mem_valid in SETTLE and IDLE leaves the line and counter alone
        for (int k = 0; k < 8; k++) wt[k] = 0;
        fill(32'h0000_0A00, wt, 32'h5555_0000, 1'b0, 32'h0000_0A00, stl, w3v, fa);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_quiet("spur");
            chk("spur addr", mem_addr, 32'h0000_0A00);
            chk_line("spur");
        end
        mem_valid = 1'b0;
        fill(32'h0000_0B04, wt, 32'h0, 1'b0, 32'h0000_0B04, stl, w3v, fa);
        chk("spur next base", fa, 32'h0000_0B00);
        step();

        // miss held through UPDATE/SETTLE: no refill of the old line, new line after SETTLE
        fill(32'h0000_0200, wt, 32'h0, 1'b1, 32'h0000_0400, stl, w3v, fa);
        chk("hold base", fa, 32'h0000_0200);
        step();
        chk_quiet("hold no refill");
        fill(32'h0000_0400, wt, 32'h0, 1'b0, 32'h0000_0400, stl, w3v, fa);
        chk("hold new base", fa, 32'h0000_0400);
        step();

        // Reset after word 4 of a fill aborts it and clears the partial line
        miss = 1'b1;
        PC   = 32'h0000_0880;
        step();
        miss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1;
            mem_rdata = 32'h1111_0000 + 32'(k);
            step();
        end
        mem_valid = 1'b0;
        chk("pre-rst req", 32'(mem_req), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) exp_w[k] = '0;
        chk_quiet("mid rst");
        chk("mid rst addr", mem_addr, 32'd0);
        chk_line("mid rst");
        step();
        chk_quiet("rst hold");
        RST_N = 1'b1;
        step();
        chk_quiet("rst release");
        fill(32'h0000_0100, wt, 32'h7777_0000, 1'b0, 32'h0000_0100, stl, w3v, fa);
        chk("rst refill base", fa, 32'h0000_0100);
        chk("rst refill w3", w3v, 32'h7777_010C);
        step();

        // Randomized fills against the line-level model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] rpc;
            logic [31:0] rkey;
            logic [31:0] rafter;
            bit          hold;
            rpc    = $urandom;
            rkey   = $urandom;
            rafter = $urandom;
            hold   = 1'($urandom_range(0, 1));
            sum    = 1;
            for (int k = 0; k < 8; k++) begin
                wt[k] = $urandom_range(0, 3);
                sum  += wt[k] + 1;
            end
            fill(rpc, wt, rkey, hold, rafter, stl, w3v, fa);
            chk($sformatf("rnd%0d stall", i), 32'(stl), 32'(sum));
            miss = 1'b0;
            gap  = $urandom_range(1, 3);
            for (int c = 0; c < gap; c++) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                step();
                chk_quiet("rnd gap");
                chk_line("rnd gap");
            end
            mem_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
